// File: rtl/arqui_check_monitor.sv
// Scoreboard downstream of the architecture checker: settles after reset, counts mismatches, detects error runs, reports pass/fail.
// Optional first-error data snapshot is built when ARQUI_CHECK_MONITOR_SNAPSHOT_EN is defined.
module arqui_check_monitor #(
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RUN       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chk_valid,
  input  logic             check_in,
  input  logic [3:0]       data0_c,
  input  logic [3:0]       data0_e,
  input  logic [3:0]       data1_c,
  input  logic [3:0]       data1_e,
  input  logic             end_of_test,
  output logic             monitoring,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] first_err_cycle,
  output logic             first_err_valid,
  output logic [15:0]      first_err_snap,
  output logic             fail,
  output logic             report_valid,
  output logic             pass,
  output logic [2:0]       state_dbg
);

  // Debug encoding: 0 SETTLE, 1 MONITOR, 2 ERROR_RUN, 3 FAIL, 4 DONE.
  typedef enum logic [2:0] {
    ST_SETTLE    = 3'd0,
    ST_MONITOR   = 3'd1,
    ST_ERROR_RUN = 3'd2,
    ST_FAIL      = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam state_t RESET_STATE = (SETTLE_CYCLES == 0) ? ST_MONITOR : ST_SETTLE;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0] RUN_MAX = 4'(MAX_RUN);

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [3:0]    run;
  logic          in_mon;
  logic          counted;

  assign in_mon     = (state == ST_MONITOR) || (state == ST_ERROR_RUN) || (state == ST_FAIL);
  assign counted    = in_mon && chk_valid && !check_in;
  assign monitoring = in_mon;
  assign pass       = (state == ST_DONE) && (mismatch_count == '0) && !fail;
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= RESET_STATE;
      settle_cnt      <= '0;
      run             <= '0;
      mismatch_count  <= '0;
      cycle_count     <= '0;
      first_err_cycle <= '0;
      first_err_valid <= 1'b0;
      fail            <= 1'b0;
      report_valid    <= 1'b0;
    end else begin
      report_valid <= 1'b0;
      case (state)
        ST_SETTLE: begin
          if (end_of_test) begin
            state        <= ST_DONE;
            report_valid <= 1'b1;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= ST_MONITOR;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_MONITOR, ST_ERROR_RUN, ST_FAIL: begin
          if (cycle_count != CNT_MAX) cycle_count <= cycle_count + 1'b1;
          if (counted) begin
            if (mismatch_count != CNT_MAX) mismatch_count <= mismatch_count + 1'b1;
            if (!first_err_valid) begin
              first_err_cycle <= cycle_count;
              first_err_valid <= 1'b1;
            end
          end
          case (state)
            ST_MONITOR: begin
              if (counted) begin
                run <= 4'd1;
                if (RUN_MAX == 4'd1) begin
                  state <= ST_FAIL;
                  fail  <= 1'b1;
                end else begin
                  state <= ST_ERROR_RUN;
                end
              end
            end
            ST_ERROR_RUN: begin
              // Invalid cycles neither extend nor break the run.
              if (counted) begin
                run <= 4'(run + 4'd1);
                if (4'(run + 4'd1) == RUN_MAX) begin
                  state <= ST_FAIL;
                  fail  <= 1'b1;
                end
              end else if (chk_valid) begin
                run   <= '0;
                state <= ST_MONITOR;
              end
            end
            default: ;
          endcase
          // The compare sample on this edge is already accounted for above.
          if (end_of_test) begin
            state        <= ST_DONE;
            report_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ARQUI_CHECK_MONITOR_SNAPSHOT_EN
  logic [15:0] snap_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q <= '0;
    end else if (counted && !first_err_valid) begin
      snap_q <= {data1_e, data1_c, data0_e, data0_c};
    end
  end
  assign first_err_snap = snap_q;
`else
  assign first_err_snap = 16'h0000;
`endif

endmodule

// File: tb/tb_arqui_check_monitor.sv
// Bench for arqui_check_monitor: table-driven vectors through an expected queue, plus a narrow-counter
// instance (CNT_W=4, SETTLE_CYCLES=0, MAX_RUN=1) for saturation and single-mismatch-fail boundaries.
module tb_arqui_check_monitor;

  typedef struct packed {
    logic        mon, fail, rv, pass, fev;
    logic [15:0] mm, cc, fec, snap;
  } obs_t;

  typedef struct {
    logic        rst, cv, ci, eot;
    logic [15:0] d;
    obs_t        exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, chk_valid = 1'b0, check_in = 1'b1, end_of_test = 1'b0;
  logic [15:0] d = '0;
  logic        monitoring, first_err_valid, fail, report_valid, pass;
  logic [15:0] mismatch_count, cycle_count, first_err_cycle, first_err_snap;
  logic [2:0]  state_dbg;

  arqui_check_monitor u_dut (
    .clk(clk), .reset(reset), .chk_valid(chk_valid), .check_in(check_in),
    .data0_c(d[3:0]), .data0_e(d[7:4]), .data1_c(d[11:8]), .data1_e(d[15:12]),
    .end_of_test(end_of_test), .monitoring(monitoring), .mismatch_count(mismatch_count),
    .cycle_count(cycle_count), .first_err_cycle(first_err_cycle), .first_err_valid(first_err_valid),
    .first_err_snap(first_err_snap), .fail(fail), .report_valid(report_valid), .pass(pass),
    .state_dbg(state_dbg)
  );

  logic        s_reset = 1'b1, s_cv = 1'b0, s_ci = 1'b1, s_eot = 1'b0;
  logic [15:0] s_d = '0;
  logic        s_mon, s_fev, s_fail, s_rv, s_pass;
  logic [3:0]  s_mm, s_cc, s_fec;
  logic [15:0] s_snap;
  logic [2:0]  s_state;

  arqui_check_monitor #(.CNT_W(4), .SETTLE_CYCLES(0), .MAX_RUN(1)) u_sat (
    .clk(clk), .reset(s_reset), .chk_valid(s_cv), .check_in(s_ci),
    .data0_c(s_d[3:0]), .data0_e(s_d[7:4]), .data1_c(s_d[11:8]), .data1_e(s_d[15:12]),
    .end_of_test(s_eot), .monitoring(s_mon), .mismatch_count(s_mm), .cycle_count(s_cc),
    .first_err_cycle(s_fec), .first_err_valid(s_fev), .first_err_snap(s_snap), .fail(s_fail),
    .report_valid(s_rv), .pass(s_pass), .state_dbg(s_state)
  );

  // ---------------- scoreboard ----------------
  logic [$bits(obs_t)-1:0] exp_q[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [15:0] snap_of(input logic [15:0] x);
`ifdef ARQUI_CHECK_MONITOR_SNAPSHOT_EN
    return x;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic add(input logic rst, cv, ci, eot, input logic [15:0] dv,
                     input logic mon, fl, rv, ps, fev, input int mm, cc, fec,
                     input logic [15:0] snap);
    vec_t v;
    v.rst = rst; v.cv = cv; v.ci = ci; v.eot = eot; v.d = dv;
    v.exp = '{mon: mon, fail: fl, rv: rv, pass: ps, fev: fev,
              mm: 16'(mm), cc: 16'(cc), fec: 16'(fec), snap: snap_of(snap)};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  initial begin
    obs_t got, exp;

    // A: settle ignores mismatches, 10 matched cycles, clean pass
    for (int i = 0; i < 3; i++) add(1,0,1,0,16'h0, 0,0,0,0,0, 0,0,0, 16'h0);
    add(0,1,0,0,16'h0, 0,0,0,0,0, 0,0,0, 16'h0);
    add(0,1,0,0,16'h0, 1,0,0,0,0, 0,0,0, 16'h0);
    for (int k = 1; k <= 9; k++) add(0,1,1,0,16'h0, 1,0,0,0,0, 0,k,0, 16'h0);
    add(0,1,1,1,16'h0, 0,0,1,1,0, 0,10,0, 16'h0);
    add(0,1,0,0,16'h0, 0,0,0,1,0, 0,10,0, 16'h0);
    // B: single mismatch at cycle 5 with snapshot
    add(1,0,1,0,16'h0, 0,0,0,0,0, 0,0,0, 16'h0);
    add(0,0,1,0,16'h0, 0,0,0,0,0, 0,0,0, 16'h0);
    add(0,0,1,0,16'h0, 1,0,0,0,0, 0,0,0, 16'h0);
    for (int k = 1; k <= 5; k++) add(0,1,1,0,16'h0, 1,0,0,0,0, 0,k,0, 16'h0);
    add(0,1,0,0,16'h3C5A, 1,0,0,0,1, 1,6,5, 16'h3C5A);
    add(0,1,1,0,16'h0,    1,0,0,0,1, 1,7,5, 16'h3C5A);
    add(0,0,1,1,16'h0,    0,0,1,0,1, 1,8,5, 16'h3C5A);
    add(0,0,1,0,16'h0,    0,0,0,0,1, 1,8,5, 16'h3C5A);
    // C: four consecutive mismatches -> sticky fail, then reset out of FAIL
    add(1,0,1,0,16'h0, 0,0,0,0,0, 0,0,0, 16'h0);
    add(0,0,1,0,16'h0, 0,0,0,0,0, 0,0,0, 16'h0);
    add(0,0,1,0,16'h0, 1,0,0,0,0, 0,0,0, 16'h0);
    add(0,1,0,0,16'h1111, 1,0,0,0,1, 1,1,0, 16'h1111);
    add(0,1,0,0,16'h2222, 1,0,0,0,1, 2,2,0, 16'h1111);
    add(0,1,0,0,16'h2222, 1,0,0,0,1, 3,3,0, 16'h1111);
    add(0,1,0,0,16'h2222, 1,1,0,0,1, 4,4,0, 16'h1111);
    add(0,1,1,0,16'h0,    1,1,0,0,1, 4,5,0, 16'h1111);
    add(1,1,0,0,16'h0,    0,0,0,0,0, 0,0,0, 16'h0);
    // D: invalid cycles do not break the run
    add(0,0,1,0,16'h0, 0,0,0,0,0, 0,0,0, 16'h0);
    add(0,0,1,0,16'h0, 1,0,0,0,0, 0,0,0, 16'h0);
    add(0,1,0,0,16'h0042, 1,0,0,0,1, 1,1,0, 16'h0042);
    for (int k = 2; k <= 4; k++) add(0,0,0,0,16'h0, 1,0,0,0,1, 1,k,0, 16'h0042);
    add(0,1,0,0,16'h0, 1,0,0,0,1, 2,5,0, 16'h0042);
    add(0,1,0,0,16'h0, 1,0,0,0,1, 3,6,0, 16'h0042);
    add(0,1,0,0,16'h0, 1,1,0,0,1, 4,7,0, 16'h0042);
    // E: end_of_test on the same edge as a mismatch, then DONE ignores inputs
    add(1,0,1,0,16'h0, 0,0,0,0,0, 0,0,0, 16'h0);
    add(0,0,1,0,16'h0, 0,0,0,0,0, 0,0,0, 16'h0);
    add(0,0,1,0,16'h0, 1,0,0,0,0, 0,0,0, 16'h0);
    add(0,1,1,0,16'h0, 1,0,0,0,0, 0,1,0, 16'h0);
    add(0,1,0,1,16'h00F0, 0,0,1,0,1, 1,2,1, 16'h00F0);
    add(0,1,0,1,16'h0F0F, 0,0,0,0,1, 1,2,1, 16'h00F0);
    add(0,1,0,0,16'h0F0F, 0,0,0,0,1, 1,2,1, 16'h00F0);
    // F: end_of_test during SETTLE, then reset out of DONE
    add(1,0,1,0,16'h0, 0,0,0,0,0, 0,0,0, 16'h0);
    add(0,1,0,1,16'h0, 0,0,1,1,0, 0,0,0, 16'h0);
    add(0,1,0,0,16'h0, 0,0,0,1,0, 0,0,0, 16'h0);
    add(1,0,1,0,16'h0, 0,0,0,0,0, 0,0,0, 16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; chk_valid = vecs[i].cv; check_in = vecs[i].ci;
      end_of_test = vecs[i].eot; d = vecs[i].d;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      got = '{mon: monitoring, fail: fail, rv: report_valid, pass: pass, fev: first_err_valid,
              mm: mismatch_count, cc: cycle_count, fec: first_err_cycle, snap: first_err_snap};
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL vec%0d: got mon=%b fail=%b rv=%b pass=%b fev=%b mm=%0d cc=%0d fec=%0d snap=%h / expected mon=%b fail=%b rv=%b pass=%b fev=%b mm=%0d cc=%0d fec=%0d snap=%h",
                 i, got.mon, got.fail, got.rv, got.pass, got.fev, got.mm, got.cc, got.fec, got.snap,
                 exp.mon, exp.fail, exp.rv, exp.pass, exp.fev, exp.mm, exp.cc, exp.fec, exp.snap);
      end
    end
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    end

    // Narrow instance: no settle window, one mismatch fails, counters saturate at 15.
    @(posedge clk); #1;
    chk("sat_reset_mon", s_mon, 1);
    chk("sat_reset_mm", s_mm, 0);
    s_reset = 1'b0; s_cv = 1'b1; s_ci = 1'b0; s_d = 16'hBEEF;
    @(posedge clk); #1;
    chk("sat_fail_first", s_fail, 1);
    chk("sat_mm_first", s_mm, 1);
    chk("sat_snap", s_snap, int'(snap_of(16'hBEEF)));
    s_d = 16'h1234;
    for (int k = 2; k <= 20; k++) begin
      @(posedge clk); #1;
      chk("sat_mm", s_mm, (k > 15) ? 15 : k);
      chk("sat_cc", s_cc, (k > 15) ? 15 : k);
    end
    s_ci = 1'b1; s_eot = 1'b1;
    @(posedge clk); #1;
    chk("sat_rv", s_rv, 1);
    chk("sat_pass_saturated", s_pass, 0);
    chk("sat_state_done", s_state, 4);
    chk("sat_fec", s_fec, 0);
    chk("sat_snap_hold", s_snap, int'(snap_of(16'hBEEF)));
    s_eot = 1'b0;
    @(posedge clk); #1;
    chk("sat_rv_pulse", s_rv, 0);
    chk("sat_mon_done", s_mon, 0);
    chk("sat_fev", s_fev, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arqui_check_monitor.md
Name: arqui_check_monitor

Overview:
- Sequential scoreboard directly downstream of the architecture checker.
- Consumes the per-cycle compare result (`arqui_checks_out`) and the two 4-bit data pairs being compared, conductual (`_c`) and estructural (`_e`).
- Suppresses the post-reset settling window, counts mismatches and tracks consecutive-error runs, and records the first failure.
- At end of test, emits a single registered pass/fail report the testbench top can sample.

Parameters:
- CNT_W, 16: width of the cycle, mismatch and first-error counters.
- SETTLE_CYCLES, 2: cycles after reset release during which compare results are ignored; 0 means monitor from the first cycle.
- MAX_RUN, 4: consecutive counted mismatches that force the sticky FAIL state; legal range 1..15.

Ports:
- clk  input  1  design clock.
- reset  input  1  synchronous, active-high reset.
- chk_valid  input  1  qualifies check_in and the data buses this cycle.
- check_in  input  1  compare result from the checker; 1 = match, 0 = mismatch.
- data0_c  input  4  conductual output 0.
- data0_e  input  4  estructural output 0.
- data1_c  input  4  conductual output 1.
- data1_e  input  4  estructural output 1.
- end_of_test  input  1  request the final report.
- monitoring  output  1  high while in MONITOR, ERROR_RUN or FAIL.
- mismatch_count  output  CNT_W  counted mismatches; saturates at all-ones.
- cycle_count  output  CNT_W  monitored cycles; saturates at all-ones.
- first_err_cycle  output  CNT_W  cycle_count value at the first counted mismatch.
- first_err_valid  output  1  a first error has been captured.
- first_err_snap  output  16  {data1_e, data1_c, data0_e, data0_c} at the first mismatch.
- fail  output  1  sticky; MAX_RUN consecutive mismatches reached.
- report_valid  output  1  one-cycle pulse on entry to DONE.
- pass  output  1  high in DONE when mismatch_count==0 and fail==0.

Behaviour:
- Clock and reset:
  - Single clock domain; all state is updated on the rising edge of clk.
  - Reset is synchronous, active-high, and has priority over every other input.
- Reset values:
  - State: SETTLE, or MONITOR if SETTLE_CYCLES==0.
  - All counters, run counter, first_err_cycle and first_err_snap: 0.
  - first_err_valid, fail, report_valid: 0.
  - pass and monitoring are decoded from state and registers.
- Latency: inputs sampled at edge N are reflected in the outputs after edge N (1 cycle).
- "Counted mismatch": chk_valid=1 && check_in=0, in MONITOR, ERROR_RUN or FAIL.
- SETTLE:
  - Settle counter increments every cycle; check_in is ignored and no counter other than settle moves.
  - Move to MONITOR when the settle counter reaches SETTLE_CYCLES-1.
- MONITOR:
  - cycle_count increments every cycle, saturating.
  - On a counted mismatch: mismatch_count++ (saturating) and run=1.
  - If first_err_valid==0: first_err_cycle = current cycle_count (pre-increment value), snapshot captured, first_err_valid=1.
  - Next state: FAIL if MAX_RUN==1, otherwise ERROR_RUN.
- ERROR_RUN:
  - On a counted mismatch: run++ and mismatch_count++. When run reaches MAX_RUN, go to FAIL and set fail=1.
  - chk_valid=1 && check_in=1: run=0, return to MONITOR.
  - chk_valid=0: hold run and state.
- FAIL:
  - fail stays 1 until reset.
  - Mismatches and cycles keep being counted.
- end_of_test sampled high in any state except DONE:
  - The same-edge compare sample is processed first.
  - Next state is DONE; report_valid=1 for exactly one cycle.
- end_of_test during SETTLE: enter DONE with counts 0, so pass=1.
- DONE:
  - All inputs except reset are ignored.
  - Counters freeze; monitoring=0.
  - pass = (mismatch_count==0) && !fail, held until reset.
- Saturation: mismatch_count and cycle_count stop at 2^CNT_W-1 and never wrap. A saturated mismatch_count still keeps pass=0.
- Reset in mid-run or in DONE: every register returns to its reset value on that edge.

Optional Feature:
- Macro name: ARQUI_CHECK_MONITOR_SNAPSHOT_EN.
- Defined: first_err_snap captures {data1_e, data1_c, data0_e, data0_c} at the first counted mismatch and holds it until reset.
- Undefined: the snapshot register is not built and first_err_snap is tied to 16'h0000. All other behaviour is unchanged.

Test Plan:
- Reset 3 cycles, release, check_in=0 with chk_valid=1 for 2 cycles, then matches for 10 cycles, end_of_test -> mismatch_count=0, cycle_count=10, report_valid pulses once, pass=1.
- After settle, 5 match cycles, then one mismatch with data0_c=4'hA, data0_e=4'h5, then match -> mismatch_count=1, first_err_cycle=5, first_err_snap[7:0]=8'h5A (feature on), fail=0, pass=0 after end_of_test.
- 4 consecutive counted mismatches (MAX_RUN=4) -> fail=1 after the 4th edge; a following match does not clear fail.
- Mismatch, chk_valid=0 for 3 cycles, mismatch, mismatch, mismatch -> run never cleared by invalid cycles, fail=1 after the 4th mismatch.
- end_of_test on the same edge as a mismatch -> mismatch_count increments, DONE entered, pass=0; later inputs leave all outputs unchanged.
- Reset asserted while in FAIL -> next cycle fail=0, counters 0, state SETTLE, report_valid=0.
